// File: rtl/uart_rx_fifo.sv
// 16x oversampled 8N1 UART receiver feeding a small show-ahead FIFO.
// Reports stop-bit framing errors (one-cycle pulse) and sticky overrun.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ     = 4000000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun,
    output logic       rx_busy
);

    localparam int unsigned DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, sync2_q, rxs;
    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic            tick;
    logic [3:0]      samp_q, samp_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;

    logic            frame_start, samp_clr, shift_en, push;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overrun_q;
    logic            full, pop, push_ok;

    assign rxs  = sync2_q;
    assign tick = (div_cnt_q == DW'(DIV - 1));

    // State register
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (!rxs) state_d = StStart;
            StStart:    if (tick && samp_q == 4'd7) state_d = rxs ? StIdle : StData;
            StData:     if (tick && samp_q == 4'd15 && bit_idx_q == 3'd7) state_d = StStop;
            StStop:     if (tick && samp_q == 4'd15) state_d = rxs ? StIdle : StWaitHigh;
            StWaitHigh: if (rxs) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        frame_start  = 1'b0;
        samp_clr     = 1'b0;
        shift_en     = 1'b0;
        push         = 1'b0;
        rx_frame_err = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rxs) begin
                    frame_start = 1'b1;
                    samp_clr    = 1'b1;
                end
            end
            StStart: if (tick && samp_q == 4'd7 && !rxs) samp_clr = 1'b1;
            StData:  if (tick && samp_q == 4'd15) shift_en = 1'b1;
            StStop: begin
                if (tick && samp_q == 4'd15) begin
                    push         = rxs;
                    rx_frame_err = ~rxs;
                end
            end
            default: ;
        endcase
    end

    assign rx_busy = (state_q != StIdle);

    // Receive datapath next-state; samp wraps 15->0 naturally between bits
    always_comb begin
        div_cnt_d = div_cnt_q + DW'(1);
        if (frame_start || tick) div_cnt_d = '0;

        samp_d = samp_q;
        if (samp_clr)  samp_d = 4'd0;
        else if (tick) samp_d = samp_q + 4'd1;

        bit_idx_d = bit_idx_q;
        if (frame_start)   bit_idx_d = 3'd0;
        else if (shift_en) bit_idx_d = bit_idx_q + 3'd1;

        shift_d = shift_q;
        if (shift_en) shift_d = {rxs, shift_q[7:1]};
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            div_cnt_q <= '0;
            samp_q    <= 4'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
        end else begin
            sync1_q   <= ser_rx;
            sync2_q   <= sync1_q;
            div_cnt_q <= div_cnt_d;
            samp_q    <= samp_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // FIFO: full is judged before the same-cycle pop, so push+pop on full still fits
    assign rx_valid = (count_q != '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = rx_valid & rx_ready;
    assign push_ok  = push & (~full | pop);
    assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign rx_overrun = overrun_q;

    always_ff @(posedge sys_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push && full && !pop) overrun_q <= 1'b1;
            else if (pop)             overrun_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at default parameters (416 clocks per bit).
module tb_uart_rx_fifo;

    localparam int BIT = 416;

    logic       sys_clk  = 1'b0;
    logic       reset_n  = 1'b0;
    logic       ser_rx   = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_busy;

    uart_rx_fifo dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .ser_rx      (ser_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_frame_err(rx_frame_err),
        .rx_overrun  (rx_overrun),
        .rx_busy     (rx_busy)
    );

    always #5 sys_clk = ~sys_clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] pop_q[$];
    int         ferr_cyc = 0;
    int         ovr_cyc  = 0;

    // Observe accepted bytes and flag activity away from the rising edge
    always @(negedge sys_clk) begin
        if (reset_n) begin
            if (rx_valid && rx_ready) pop_q.push_back(rx_data);
            if (rx_frame_err) ferr_cyc++;
            if (rx_overrun) ovr_cyc++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < pop_q.size()) return pop_q[i];
        return 8'hxx;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Line is left at the stop-bit level on return
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        ser_rx = 1'b0;
        wait_cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            wait_cycles(BIT);
        end
        ser_rx = stop_bit;
        wait_cycles(BIT);
    endtask

    initial begin
        int f0;
        int o0;

        wait_cycles(3);
        check_eq("rst_valid", rx_valid, 1'b0);
        check_eq("rst_data", rx_data, 8'h00);
        check_eq("rst_ferr", rx_frame_err, 1'b0);
        check_eq("rst_ovr", rx_overrun, 1'b0);
        check_eq("rst_busy", rx_busy, 1'b0);
        reset_n = 1'b1;
        wait_cycles(20);

        // Back-to-back 0x55, 0xA3
        rx_ready = 1'b1;
        pop_q.delete();
        send_byte(8'h55, 1'b1);
        send_byte(8'hA3, 1'b1);
        wait_cycles(50);
        check_eq("b2b_npop", pop_q.size(), 2);
        check_eq("b2b_pop0", q_at(0), 8'h55);
        check_eq("b2b_pop1", q_at(1), 8'hA3);
        check_eq("b2b_ferr", ferr_cyc, 0);
        check_eq("b2b_ovr", ovr_cyc, 0);
        check_eq("b2b_busy", rx_busy, 1'b0);

        // 52-cycle low glitch is rejected at mid start bit
        pop_q.delete();
        ser_rx = 1'b0;
        wait_cycles(30);
        check_eq("gl_busy_in", rx_busy, 1'b1);
        wait_cycles(22);
        ser_rx = 1'b1;
        wait_cycles(2 * BIT);
        check_eq("gl_busy_out", rx_busy, 1'b0);
        check_eq("gl_npop", pop_q.size(), 0);
        check_eq("gl_valid", rx_valid, 1'b0);

        // Framing error followed by a held-low line, then a good frame
        f0 = ferr_cyc;
        send_byte(8'h3C, 1'b0);
        wait_cycles(2 * BIT);
        check_eq("fe_pulse", ferr_cyc - f0, 1);
        check_eq("fe_npop", pop_q.size(), 0);
        check_eq("fe_busy_low", rx_busy, 1'b1);
        ser_rx = 1'b1;
        wait_cycles(BIT);
        check_eq("fe_busy_high", rx_busy, 1'b0);
        send_byte(8'h7E, 1'b1);
        wait_cycles(50);
        check_eq("fe_npop2", pop_q.size(), 1);
        check_eq("fe_pop0", q_at(0), 8'h7E);
        check_eq("fe_pulse2", ferr_cyc - f0, 1);

        // Overrun: five bytes into a four-entry FIFO with no consumer
        rx_ready = 1'b0;
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
        wait_cycles(50);
        check_eq("ov_valid4", rx_valid, 1'b1);
        check_eq("ov_data4", rx_data, 8'h01);
        check_eq("ov_ovr4", rx_overrun, 1'b0);
        send_byte(8'h05, 1'b1);
        wait_cycles(50);
        check_eq("ov_ovr5", rx_overrun, 1'b1);
        check_eq("ov_data5", rx_data, 8'h01);
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check_eq($sformatf("ov_pop%0d_valid", i), rx_valid, 1'b1);
            check_eq($sformatf("ov_pop%0d_data", i), rx_data, 8'(i + 1));
            check_eq($sformatf("ov_pop%0d_ovr", i), rx_overrun, (i == 0) ? 1'b1 : 1'b0);
            @(posedge sys_clk);
            #1;
        end
        @(negedge sys_clk);
        check_eq("ov_empty", rx_valid, 1'b0);
        @(posedge sys_clk);
        #1;

        // Full FIFO, fifth push coincides with a single pop
        rx_ready = 1'b0;
        for (int b = 1; b <= 4; b++) send_byte(8'(b), 1'b1);
        o0 = ovr_cyc;
        fork
            send_byte(8'h05, 1'b1);
            begin
                wait_cycles(3954);
                rx_ready = 1'b1;
                wait_cycles(1);
                rx_ready = 1'b0;
            end
        join
        wait_cycles(50);
        check_eq("pp_ovr", rx_overrun, 1'b0);
        check_eq("pp_ovr_cyc", ovr_cyc - o0, 0);
        check_eq("pp_head", rx_data, 8'h02);
        pop_q.delete();
        rx_ready = 1'b1;
        wait_cycles(10);
        rx_ready = 1'b0;
        check_eq("pp_npop", pop_q.size(), 4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("pp_pop%0d", i), q_at(i), 8'(i + 2));
        check_eq("pp_empty", rx_valid, 1'b0);

        // Reset pulse during bit 4 of a frame with a byte already queued
        send_byte(8'h5A, 1'b1);
        wait_cycles(50);
        check_eq("rs_pre_valid", rx_valid, 1'b1);
        check_eq("rs_pre_data", rx_data, 8'h5A);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                wait_cycles(5 * BIT + BIT / 2);
                check_eq("rs_pre_busy", rx_busy, 1'b1);
                reset_n = 1'b0;
                #1;
                check_eq("rs_valid", rx_valid, 1'b0);
                check_eq("rs_data", rx_data, 8'h00);
                check_eq("rs_busy", rx_busy, 1'b0);
                check_eq("rs_ferr", rx_frame_err, 1'b0);
                check_eq("rs_ovr", rx_overrun, 1'b0);
                wait_cycles(100);
                reset_n = 1'b1;
            end
        join
        wait_cycles(50);
        check_eq("rs_post_valid", rx_valid, 1'b0);
        check_eq("rs_post_busy", rx_busy, 1'b0);
        rx_ready = 1'b1;
        pop_q.delete();
        send_byte(8'hC9, 1'b1);
        wait_cycles(50);
        check_eq("rs_npop", pop_q.size(), 1);
        check_eq("rs_pop0", q_at(0), 8'hC9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial receive front end between the ser_rx board pin and the SC/MP I/O logic on the tangnano20kdock top.
- Performs 16x oversampled 8N1 UART reception and buffers received bytes in a small FIFO.
- Presents bytes on a show-ahead valid/ready interface.
- Reports framing errors and overrun.

Parameters:
- CLK_HZ, 4000000, sys_clk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- FIFO_DEPTH, 4, FIFO entries; must be a power of two, 2..16.
- DIV (localparam), round(CLK_HZ/(16*BAUD)) = 26, sys_clk cycles per oversample tick; must be >= 2.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ser_rx  in  1  raw serial line; idles high; asynchronous to sys_clk.
- rx_data  out  8  byte at the FIFO head; valid only while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head byte when rx_valid=1 and rx_ready=1.
- rx_frame_err  out  1  one-cycle pulse when a stop bit is sampled low.
- rx_overrun  out  1  sticky flag: a byte was dropped because the FIFO was full.
- rx_busy  out  1  receiver state is not IDLE.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Synchronizer flops are set to 1; state goes to IDLE; all counters are 0; FIFO is empty.
  - Outputs: rx_valid=0, rx_data=0, rx_frame_err=0, rx_overrun=0, rx_busy=0.
  - Reset asserted mid-frame abandons the frame; no partial byte is ever pushed.
- Synchronizer: two flops on ser_rx feed rxs. All decisions use rxs, so there are 2 cycles of input latency.
- Tick generator:
  - div_cnt counts 0..DIV-1, wraps, and asserts tick for one cycle at DIV-1.
  - div_cnt is forced to 0 on the cycle the FSM leaves IDLE, so ticks are phase-aligned to the start edge.
  - A 4-bit sample counter samp advances on each tick.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rxs=0, set samp=0 and bit index=0, then go to START.
  - START: on the tick where samp=7 (mid start bit):
    - if rxs=1, it was a glitch; go to IDLE with nothing reported;
    - otherwise set samp=0 and go to DATA.
  - DATA: on each tick where samp=15 (mid bit):
    - shift rxs into the MSB of the shift register, so bits land LSB-first;
    - increment the bit index;
    - after the 8th bit, go to STOP.
  - STOP: on the tick where samp=15 (mid stop bit):
    - if rxs=1, push the byte and go to IDLE immediately; this tolerates a next start edge in the second half of the stop bit;
    - if rxs=0, pulse rx_frame_err for 1 cycle, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a break condition from producing repeated frames.
- FIFO:
  - Circular buffer with read pointer, write pointer and count register (0..FIFO_DEPTH).
  - push is a 1-cycle pulse from STOP.
  - pop = rx_valid & rx_ready.
  - rx_data shows the head entry combinationally from the registered read pointer.
  - rx_valid = (count != 0).
  - A pushed byte is visible on rx_valid/rx_data on the cycle after the push.
  - The full check is made against count before any pop in the same cycle:
    - full and no pop: byte is dropped and rx_overrun is set;
    - full and pop in the same cycle: both occur, count is unchanged, no overrun.
  - Empty with push: push only. A pop while empty is impossible, because rx_valid=0.
  - rx_overrun stays set until the next pop cycle and clears on that pop.
  - Pointers wrap modulo FIFO_DEPTH.
- Timing at defaults:
  - 1 bit = 16*26 = 416 cycles = 104 us at 4 MHz.
  - Push occurs about 9.5 bit times plus 2 cycles after the start edge.

Test Plan:
- 0x55 then 0xA3 sent back-to-back at 9600 baud, one stop bit each, rx_ready=1 -> rx_valid pulses twice; rx_data reads 0x55 then 0xA3; rx_frame_err and rx_overrun stay 0; rx_busy=0 after the stops.
- Low glitch on ser_rx lasting 2 ticks (52 cycles) -> FSM returns to IDLE at samp=7; no push; rx_valid stays 0.
- 0x3C sent with stop bit=0, then line held low for 2 bit times -> exactly one 1-cycle rx_frame_err pulse; no push; no new frame until the line returns high, then a following 0x7E is received correctly.
- Bytes 0x01..0x05 sent with rx_ready=0 -> count=4; rx_overrun=1 after the 5th byte; then raising rx_ready pops 0x01,0x02,0x03,0x04 in 4 consecutive cycles; rx_overrun clears on the first pop; rx_valid=0 afterwards.
- FIFO full, and the 5th byte's push coincides with a pop (rx_ready pulsed on that cycle) -> 0x01 leaves, 0x05 is stored at the tail, count stays 4, rx_overrun stays 0.
- reset_n pulsed low during bit 4 of a frame -> all outputs go to their reset values immediately; no byte is pushed; the next full frame 0xC9 is received correctly.
